// File: rtl/branch_format_decoder_pkg.sv
// Shared decode constants and types for the branch format decoder.
package branch_format_decoder_pkg;

  typedef enum logic [1:0] {UOP_BR = 2'd0, UOP_CTR = 2'd1, UOP_LR = 2'd2} uop_kind_e;
  typedef enum logic [1:0] {TGT_REL = 2'd0, TGT_LR = 2'd1, TGT_CTR = 2'd2} target_e;
  typedef enum logic [1:0] {IDLE, EMIT_BR, EMIT_CTR, EMIT_LR} state_e;
  typedef enum logic [1:0] {FORM_I, FORM_B, FORM_XL, FORM_BAD} form_e;

  localparam logic [5:0] OPC_I    = 6'd18;
  localparam logic [5:0] OPC_B    = 6'd16;
  localparam logic [5:0] OPC_XL   = 6'd19;
  localparam logic [9:0] XO_BCLR  = 10'd16;
  localparam logic [9:0] XO_BCCTR = 10'd528;

  localparam int BRANCH_UNIT_ID = 6;
  localparam int FX_UNIT_ID     = 0;

  // Per-instruction decode held for the whole uop sequence.
  typedef struct packed {
    logic [4:0] bo;
    logic [4:0] bi;
    logic [1:0] bh;
    logic       aa;
    target_e    target;
    logic       illegal;
    logic       need_ctr;
    logic       need_lr;
  } br_dec_t;

  function automatic form_e form_of(input logic [5:0] opc);
    case (opc)
      OPC_I:   return FORM_I;
      OPC_B:   return FORM_B;
      OPC_XL:  return FORM_XL;
      default: return FORM_BAD;
    endcase
  endfunction

endpackage

// File: rtl/branch_imm_gen.sv
// Branch immediate sign-extension and link-address generation.
module branch_imm_gen
  import branch_format_decoder_pkg::*;
#(
  parameter int AW = 64
) (
  input  form_e         form_i,
  input  logic [23:0]   li_i,
  input  logic [13:0]   bd_i,
  input  logic [AW-1:0] addr_i,
  output logic [AW-1:0] br_imm_o,
  output logic [AW-1:0] lr_addr_o
);

  logic [25:0] li_ext;
  logic [15:0] bd_ext;

  assign li_ext = {li_i, 2'b00};
  assign bd_ext = {bd_i, 2'b00};

  // Select the word-aligned displacement for the form; XL-form has none.
  always_comb begin
    br_imm_o = '0;
    case (form_i)
      FORM_I:  br_imm_o = {{(AW-26){li_ext[25]}}, li_ext};
      FORM_B:  br_imm_o = {{(AW-16){bd_ext[15]}}, bd_ext};
      default: br_imm_o = '0;
    endcase
  end

  // Return address wraps naturally at the address width.
  assign lr_addr_o = addr_i + AW'(4);

endmodule

// File: rtl/branch_format_decoder.sv
// Branch decoder: cracks I/B/XL branches into BR, optional CTR and LR uops.
module branch_format_decoder
  import branch_format_decoder_pkg::*;
#(
  parameter int addressWidth            = 64,
  parameter int instructionCounterWidth = 64,
  parameter int instMinIdWidth          = 7,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int funcUnitCodeSize        = 3,
  parameter int BranchUnitId            = BRANCH_UNIT_ID,
  parameter int FXUnitId                = FX_UNIT_ID
) (
  input  logic                               clock_i,
  input  logic                               resetn_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  input  logic [0:31]                        instruction_i,
  input  logic [addressWidth-1:0]            instructionAddress_i,
  input  logic [instructionCounterWidth-1:0] instructionMajId_i,
  input  logic [PidSize-1:0]                 instructionPid_i,
  input  logic [TidSize-1:0]                 instructionTid_i,
  input  logic                               is64Bit_i,
  input  logic                               stall_i,
  input  logic                               flush_i,
  output logic                               valid_o,
  output logic [1:0]                         uopKind_o,
  output logic [funcUnitCodeSize-1:0]        functionalUnitType_o,
  output logic [instMinIdWidth-1:0]          instMinId_o,
  output logic                               illegal_o,
  output logic [4:0]                         BO_o,
  output logic [4:0]                         BI_o,
  output logic [1:0]                         BH_o,
  output logic                               AA_o,
  output logic [1:0]                         target_o,
  output logic [addressWidth-1:0]            immediate_o,
  output logic [addressWidth-1:0]            instructionAddress_o,
  output logic [instructionCounterWidth-1:0] instMajId_o,
  output logic [PidSize-1:0]                 instPid_o,
  output logic [TidSize-1:0]                 instTid_o,
  output logic                               is64Bit_o
);

  localparam int AW = addressWidth;

  state_e  state_q, state_d;
  br_dec_t dec_q, dec_d, dec_in;
  logic [AW-1:0] br_imm_q, br_imm_d, lr_imm_q, lr_imm_d, br_imm_in, lr_imm_in;
  logic [AW-1:0] addr_q, addr_d;
  logic [instructionCounterWidth-1:0] maj_q, maj_d;
  logic [PidSize-1:0] pid_q, pid_d;
  logic [TidSize-1:0] tid_q, tid_d;
  logic is64_q, is64_d;

  form_e      form;
  logic [9:0] xo;
  logic       lk, bo2_n, consume, last, accept;

  assign form  = form_of(instruction_i[0:5]);
  assign xo    = instruction_i[21:30];
  assign lk    = instruction_i[31];
  assign bo2_n = ~instruction_i[8];

  branch_imm_gen #(.AW(AW)) u_imm (
    .form_i   (form),
    .li_i     (instruction_i[6:29]),
    .bd_i     (instruction_i[16:29]),
    .addr_i   (instructionAddress_i),
    .br_imm_o (br_imm_in),
    .lr_addr_o(lr_imm_in)
  );

  // Field decode of the incoming instruction; malformed encodings become one illegal BR.
  always_comb begin
    dec_in = '0;
    case (form)
      FORM_I: begin
        dec_in.aa      = instruction_i[30];
        dec_in.need_lr = lk;
      end
      FORM_B: begin
        dec_in.bo       = instruction_i[6:10];
        dec_in.bi       = instruction_i[11:15];
        dec_in.aa       = instruction_i[30];
        dec_in.need_ctr = bo2_n;
        dec_in.need_lr  = lk;
      end
      FORM_XL: begin
        dec_in.bo = instruction_i[6:10];
        dec_in.bi = instruction_i[11:15];
        dec_in.bh = instruction_i[19:20];
        if (xo == XO_BCLR) begin
          dec_in.target   = TGT_LR;
          dec_in.need_ctr = bo2_n;
          dec_in.need_lr  = lk;
        end else if (xo == XO_BCCTR && !bo2_n) begin
          dec_in.target  = TGT_CTR;
          dec_in.need_lr = lk;
        end else begin
          dec_in.illegal = 1'b1;
        end
      end
      default: dec_in.illegal = 1'b1;
    endcase
  end

  // Sequencer: handshake, next state, and capture of a newly accepted instruction.
  always_comb begin
    valid_o = (state_q != IDLE);
    consume = valid_o && !stall_i;
    case (state_q)
      EMIT_BR:  last = !dec_q.need_ctr && !dec_q.need_lr;
      EMIT_CTR: last = !dec_q.need_lr;
      default:  last = 1'b1;
    endcase
    ready_o = !flush_i && ((state_q == IDLE) || (consume && last));
    accept  = valid_i && ready_o;

    state_d = state_q;
    if (state_q == IDLE) begin
      if (accept) state_d = EMIT_BR;
    end else if (consume) begin
      if (last)                                        state_d = accept ? EMIT_BR : IDLE;
      else if (state_q == EMIT_BR && dec_q.need_ctr)   state_d = EMIT_CTR;
      else                                             state_d = EMIT_LR;
    end
    if (flush_i) state_d = IDLE;

    dec_d    = accept ? dec_in               : dec_q;
    br_imm_d = accept ? br_imm_in            : br_imm_q;
    lr_imm_d = accept ? lr_imm_in            : lr_imm_q;
    addr_d   = accept ? instructionAddress_i : addr_q;
    maj_d    = accept ? instructionMajId_i   : maj_q;
    pid_d    = accept ? instructionPid_i     : pid_q;
    tid_d    = accept ? instructionTid_i     : tid_q;
    is64_d   = accept ? is64Bit_i            : is64_q;
  end

  // State and captured-instruction registers.
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q  <= IDLE;
      dec_q    <= '0;
      br_imm_q <= '0;
      lr_imm_q <= '0;
      addr_q   <= '0;
      maj_q    <= '0;
      pid_q    <= '0;
      tid_q    <= '0;
      is64_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dec_q    <= dec_d;
      br_imm_q <= br_imm_d;
      lr_imm_q <= lr_imm_d;
      addr_q   <= addr_d;
      maj_q    <= maj_d;
      pid_q    <= pid_d;
      tid_q    <= tid_d;
      is64_q   <= is64_d;
    end
  end

  // Per-uop fields come straight from state and captured decode, so they hold under stall.
  always_comb begin
    uopKind_o            = UOP_BR;
    functionalUnitType_o = '0;
    instMinId_o          = '0;
    illegal_o            = 1'b0;
    immediate_o          = '0;
    BO_o                 = '0;
    BI_o                 = '0;
    BH_o                 = '0;
    AA_o                 = 1'b0;
    target_o             = TGT_REL;
    if (state_q != IDLE) begin
      BO_o     = dec_q.bo;
      BI_o     = dec_q.bi;
      BH_o     = dec_q.bh;
      AA_o     = dec_q.aa;
      target_o = dec_q.target;
    end
    case (state_q)
      EMIT_BR: begin
        functionalUnitType_o = funcUnitCodeSize'(BranchUnitId);
        illegal_o            = dec_q.illegal;
        immediate_o          = br_imm_q;
      end
      EMIT_CTR: begin
        uopKind_o            = UOP_CTR;
        functionalUnitType_o = funcUnitCodeSize'(FXUnitId);
        instMinId_o          = instMinIdWidth'(1);
        immediate_o          = '1;
      end
      EMIT_LR: begin
        uopKind_o            = UOP_LR;
        functionalUnitType_o = funcUnitCodeSize'(FXUnitId);
        instMinId_o          = dec_q.need_ctr ? instMinIdWidth'(2) : instMinIdWidth'(1);
        immediate_o          = lr_imm_q;
      end
      default: ;
    endcase
  end

  assign instructionAddress_o = addr_q;
  assign instMajId_o          = maj_q;
  assign instPid_o            = pid_q;
  assign instTid_o            = tid_q;
  assign is64Bit_o            = is64_q;

endmodule

// File: tb/tb_branch_format_decoder.sv
// Randomized bench for branch_format_decoder with a queue-based uop reference model.
module tb_branch_format_decoder;

  logic        clk = 1'b0;
  logic        resetn_i, valid_i, ready_o, is64Bit_i, stall_i, flush_i;
  logic [31:0] instruction_i;
  logic [63:0] instructionAddress_i, instructionMajId_i;
  logic [19:0] instructionPid_i;
  logic [15:0] instructionTid_i;
  logic        valid_o, illegal_o, AA_o, is64Bit_o;
  logic [1:0]  uopKind_o, BH_o, target_o;
  logic [2:0]  functionalUnitType_o;
  logic [6:0]  instMinId_o;
  logic [4:0]  BO_o, BI_o;
  logic [63:0] immediate_o, instructionAddress_o, instMajId_o;
  logic [19:0] instPid_o;
  logic [15:0] instTid_o;

  always #5 clk = ~clk;

  branch_format_decoder dut (
    .clock_i(clk), .resetn_i(resetn_i), .valid_i(valid_i), .ready_o(ready_o),
    .instruction_i(instruction_i), .instructionAddress_i(instructionAddress_i),
    .instructionMajId_i(instructionMajId_i), .instructionPid_i(instructionPid_i),
    .instructionTid_i(instructionTid_i), .is64Bit_i(is64Bit_i), .stall_i(stall_i),
    .flush_i(flush_i), .valid_o(valid_o), .uopKind_o(uopKind_o),
    .functionalUnitType_o(functionalUnitType_o), .instMinId_o(instMinId_o),
    .illegal_o(illegal_o), .BO_o(BO_o), .BI_o(BI_o), .BH_o(BH_o), .AA_o(AA_o),
    .target_o(target_o), .immediate_o(immediate_o),
    .instructionAddress_o(instructionAddress_o), .instMajId_o(instMajId_o),
    .instPid_o(instPid_o), .instTid_o(instTid_o), .is64Bit_o(is64Bit_o)
  );

  typedef struct {
    logic [1:0]  kind;
    logic [2:0]  fu;
    int          minid;
    logic        ill;
    logic [4:0]  bo, bi;
    logic [1:0]  bh;
    logic        aa;
    logic [1:0]  tgt;
    logic [63:0] imm, addr, maj;
    logic [19:0] pid;
    logic [15:0] tid;
    logic        is64;
  } uop_t;

  uop_t q[$];
  int   nchk = 0, nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected uop list of one instruction, from the architectural field layout.
  function automatic void push_seq(input logic [31:0] ins, input logic [63:0] addr,
                                   input logic [63:0] maj, input logic [19:0] pid,
                                   input logic [15:0] tid, input logic is64);
    uop_t u;
    int   opc, xo, t;
    bit   ill, ctr, lr, bo2;
    u = '{default: '0};
    u.addr = addr; u.maj = maj; u.pid = pid; u.tid = tid; u.is64 = is64;
    opc = int'(ins >> 26);
    xo  = int'((ins >> 1) & 32'h3FF);
    bo2 = ((ins >> 23) & 1) != 0;
    lr  = (ins & 1) != 0;
    ill = 0; ctr = 0;
    if (opc == 18) begin
      u.aa = ins[1];
      t = int'((ins & 32'h03FF_FFFC) << 6) >>> 6;
      u.imm = longint'(t);
    end else if (opc == 16) begin
      u.bo = 5'((ins >> 21) & 31); u.bi = 5'((ins >> 16) & 31); u.aa = ins[1];
      t = int'((ins & 32'h0000_FFFC) << 16) >>> 16;
      u.imm = longint'(t);
      ctr = !bo2;
    end else if (opc == 19) begin
      u.bo = 5'((ins >> 21) & 31); u.bi = 5'((ins >> 16) & 31); u.bh = 2'((ins >> 11) & 3);
      if (xo == 16) begin u.tgt = 2'd1; ctr = !bo2; end
      else if (xo == 528 && bo2) u.tgt = 2'd2;
      else ill = 1;
    end else ill = 1;
    u.kind = 2'd0; u.fu = 3'd6; u.minid = 0; u.ill = ill;
    q.push_back(u);
    u.ill = 0;
    if (!ill && ctr) begin
      u.kind = 2'd1; u.fu = 3'd0; u.minid++; u.imm = '1; q.push_back(u);
    end
    if (!ill && lr) begin
      u.kind = 2'd2; u.fu = 3'd0; u.minid++; u.imm = addr + 64'd4; q.push_back(u);
    end
  endfunction

  task automatic chk_uop(input uop_t e);
    chk("kind", 64'(uopKind_o), 64'(e.kind));
    chk("fu", 64'(functionalUnitType_o), 64'(e.fu));
    chk("minid", 64'(instMinId_o), 64'(e.minid));
    chk("illegal", 64'(illegal_o), 64'(e.ill));
    chk("bo", 64'(BO_o), 64'(e.bo));
    chk("bi", 64'(BI_o), 64'(e.bi));
    chk("bh", 64'(BH_o), 64'(e.bh));
    chk("aa", 64'(AA_o), 64'(e.aa));
    chk("target", 64'(target_o), 64'(e.tgt));
    chk("imm", immediate_o, e.imm);
    chk("addr", instructionAddress_o, e.addr);
    chk("majid", instMajId_o, e.maj);
    chk("pid", 64'(instPid_o), 64'(e.pid));
    chk("tid", 64'(instTid_o), 64'(e.tid));
    chk("is64", 64'(is64Bit_o), 64'(e.is64));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 64'(valid_o), 64'd0);
    chk({tag, "_illegal"}, 64'(illegal_o), 64'd0);
    chk({tag, "_kind"}, 64'(uopKind_o), 64'd0);
    chk({tag, "_fu"}, 64'(functionalUnitType_o), 64'd0);
    chk({tag, "_minid"}, 64'(instMinId_o), 64'd0);
    chk({tag, "_fields"}, 64'({BO_o, BI_o, BH_o, AA_o, target_o}), 64'd0);
    chk({tag, "_imm"}, immediate_o, 64'd0);
    chk({tag, "_sideband"}, instructionAddress_o | instMajId_o | 64'(instPid_o)
        | 64'(instTid_o) | 64'(is64Bit_o), 64'd0);
  endtask

  // One cycle: drive at negedge, check against the model, then advance the model.
  task automatic step(input logic v, input logic [31:0] ins, input logic st,
                      input logic fl, input logic [63:0] addr);
    bit exp_valid, consume, exp_ready;
    @(negedge clk);
    valid_i = v; instruction_i = ins; stall_i = st; flush_i = fl;
    instructionAddress_i = addr;
    instructionMajId_i = {$urandom, $urandom};
    instructionPid_i = 20'($urandom);
    instructionTid_i = 16'($urandom);
    is64Bit_i = 1'($urandom);
    #1;
    exp_valid = q.size() != 0;
    consume   = exp_valid && !st;
    exp_ready = !fl && (q.size() == 0 || (consume && q.size() == 1));
    chk("valid_o", 64'(valid_o), 64'(exp_valid));
    chk("ready_o", 64'(ready_o), 64'(exp_ready));
    if (exp_valid) chk_uop(q[0]);
    if (fl) q.delete();
    else begin
      if (consume) void'(q.pop_front());
      if (v && exp_ready)
        push_seq(ins, addr, instructionMajId_i, instructionPid_i, instructionTid_i, is64Bit_i);
    end
  endtask

  function automatic logic [31:0] rand_ins();
    logic [31:0] r, xo;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: return (32'd18 << 26) | (r & 32'h03FF_FFFF);
      1: return (32'd16 << 26) | (r & 32'h03FF_FFFF);
      2, 3: begin
        case ($urandom_range(0, 2))
          0:       xo = 32'd16;
          1:       xo = 32'd528;
          default: xo = 32'($urandom_range(0, 1023));
        endcase
        return (32'd19 << 26) | (r & 32'h03FF_F801) | (xo << 1);
      end
      default: return r;
    endcase
  endfunction

  initial begin
    resetn_i = 1'b0; valid_i = 1'b0; instruction_i = '0; stall_i = 1'b0; flush_i = 1'b0;
    instructionAddress_i = '0; instructionMajId_i = '0; instructionPid_i = '0;
    instructionTid_i = '0; is64Bit_i = 1'b0;
    #12 chk_zero("rst");
    @(negedge clk) resetn_i = 1'b1;

    // b 0x100: single BR, next instruction taken back-to-back
    step(1, 32'h4800_0100, 0, 0, 64'h1000);
    step(1, 32'h4800_0100, 0, 0, 64'h1004);
    chk("b_imm", immediate_o, 64'h100);
    chk("b_ready", 64'(ready_o), 64'd1);
    step(0, 0, 0, 0, 0);

    // bcl BO=0: BR/CTR/LR, with a 4-cycle stall on the CTR uop
    step(1, 32'h4000_0005, 0, 0, 64'h2000);
    step(0, 0, 0, 0, 0);
    chk("bcl_br_imm", immediate_o, 64'h4);
    repeat (4) begin
      step(0, 0, 1, 0, 0);
      chk("ctr_imm", immediate_o, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("ctr_minid", 64'(instMinId_o), 64'd1);
    end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("lr_imm", immediate_o, 64'h2004);
    chk("lr_minid", 64'(instMinId_o), 64'd2);
    step(0, 0, 0, 0, 0);

    // flush while CTR is valid, with a competing valid_i
    step(1, 32'h4000_0005, 0, 0, 64'h3000);
    step(0, 0, 0, 0, 0);
    step(1, 32'h4800_0100, 0, 1, 64'h3100);
    step(0, 0, 0, 0, 0);
    chk("flush_valid", 64'(valid_o), 64'd0);
    chk("flush_ready", 64'(ready_o), 64'd1);

    // illegal XL XO and bcctr with BO[2]=0
    step(1, 32'h4C00_00C8, 0, 0, 64'h4000);
    step(0, 0, 0, 0, 0);
    chk("ill_xo", 64'(illegal_o), 64'd1);
    step(1, 32'h4C00_0421, 0, 0, 64'h4004);
    step(0, 0, 0, 0, 0);
    chk("ill_bcctr", 64'(illegal_o), 64'd1);
    step(0, 0, 0, 0, 0);

    // reset in the middle of a sequence
    step(1, 32'h4000_0005, 0, 0, 64'h5000);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    #2 resetn_i = 1'b0;
    #1 chk_zero("midrst");
    q.delete();
    @(negedge clk) resetn_i = 1'b1;
    repeat (3) step(0, 0, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      logic [63:0] a;
      a = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom};
      step(1'($urandom_range(0, 3) != 0), rand_ins(), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 19) == 0), a);
    end
    repeat (6) step(0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
